// File: rtl/reg_file_pkg.sv
// Shared defaults and types for the ARM register file.
// The top level takes its parameter defaults from here.
package reg_file_pkg;

  localparam int unsigned DATA_W      = 32;
  localparam int unsigned NUM_REGS    = 16;
  localparam int unsigned NUM_RD      = 3;
  localparam int unsigned PC_INC      = 4;
  localparam int unsigned PC_READ_OFS = 8;
  localparam int unsigned AW          = $clog2(NUM_REGS);
  localparam int unsigned PC_IDX      = NUM_REGS - 1;

  typedef logic [AW-1:0]     reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  // Architectural PC read value: the PC as seen by an instruction two slots ahead.
  function automatic reg_data_t pc_read_adj(input reg_data_t value);
    return value + reg_data_t'(PC_READ_OFS);
  endfunction

endpackage

// File: rtl/reg_read_mux.sv
// NUM_REGS:1 combinational register select for one read port.
module reg_read_mux #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 16
) (
  input  logic [NUM_REGS-1:0][DATA_W-1:0] regs,
  input  logic [$clog2(NUM_REGS)-1:0]     sel,
  output logic [DATA_W-1:0]               dout
);

  always_comb begin
    dout = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (sel == ($clog2(NUM_REGS))'(i)) dout = regs[i];
    end
  end

endmodule

// File: rtl/arm_register_file.sv
// Multi-port ARM register file: flat storage with the PC as its top entry,
// registered read ports with write-through bypass and PC read offset.
module arm_register_file
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_W      = reg_file_pkg::DATA_W,
  parameter int unsigned NUM_REGS    = reg_file_pkg::NUM_REGS,
  parameter int unsigned NUM_RD      = reg_file_pkg::NUM_RD,
  parameter int unsigned PC_INC      = reg_file_pkg::PC_INC,
  parameter int unsigned PC_READ_OFS = reg_file_pkg::PC_READ_OFS,
  localparam int unsigned AW         = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [AW-1:0]            wa,
  input  logic [DATA_W-1:0]        wd,
  input  logic                     rd_en,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic                     rd_valid,
  input  logic                     pc_inc,
  output logic [DATA_W-1:0]        pc_out
);

  localparam int unsigned PcIdx = NUM_REGS - 1;

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;
  logic [NUM_RD*DATA_W-1:0]        rd_data_d, rd_data_q;
  logic                            rd_valid_q;

  // A PC write takes priority over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (we && wa == AW'(i)) begin
          regs_q[i] <= wd;
        end else if (i == PcIdx && pc_inc) begin
          regs_q[i] <= regs_q[i] + DATA_W'(PC_INC);
        end
      end
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd_port
    logic [AW-1:0]     addr;
    logic [DATA_W-1:0] mux_val;
    logic [DATA_W-1:0] src;

    assign addr = rd_addr[p*AW +: AW];

    reg_read_mux #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS)
    ) u_mux (
      .regs (regs_q),
      .sel  (addr),
      .dout (mux_val)
    );

    // Bypass sees the write data; the PC source is pre-increment.
    assign src = (we && wa == addr) ? wd : mux_val;
    assign rd_data_d[p*DATA_W +: DATA_W] =
        (addr == AW'(PcIdx)) ? src + DATA_W'(PC_READ_OFS) : src;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) rd_data_q <= rd_data_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign pc_out   = regs_q[PcIdx];

endmodule

// File: tb/tb_arm_register_file.sv
// Directed self-checking bench for arm_register_file with default parameters.
module tb_arm_register_file;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [3:0]  wa;
  logic [31:0] wd;
  logic        rd_en;
  logic [11:0] rd_addr;
  logic [95:0] rd_data;
  logic        rd_valid;
  logic        pc_inc;
  logic [31:0] pc_out;

  int n_vec  = 0;
  int n_miss = 0;

  arm_register_file dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we),
    .wa       (wa),
    .wd       (wd),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .pc_inc   (pc_inc),
    .pc_out   (pc_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; wa = '0; wd = '0; rd_en = 1'b0; rd_addr = '0; pc_inc = 1'b0;
  endtask

  function automatic logic [31:0] port(input int p);
    return rd_data[p*32 +: 32];
  endfunction

  initial begin
    rst_n = 1'b0;
    idle();
    #1;
    check("por_pc", pc_out, 32'h0);
    check("por_valid", {31'b0, rd_valid}, 32'h0);
    step();
    rst_n = 1'b1;

    // Write R1, read it back.
    we = 1'b1; wa = 4'd1; wd = 32'hA5A5_0001;
    step();
    idle(); rd_en = 1'b1; rd_addr = {4'd0, 4'd0, 4'd1};
    step();
    check("r1_read", port(0), 32'hA5A5_0001);
    check("r1_valid", {31'b0, rd_valid}, 32'h1);

    // Mid-cycle reset with a pending write to R2.
    idle(); we = 1'b1; wa = 4'd2; wd = 32'h0000_0055;
    #2 rst_n = 1'b0;
    #1;
    check("rst_data0", port(0), 32'h0);
    check("rst_valid", {31'b0, rd_valid}, 32'h0);
    check("rst_pc", pc_out, 32'h0);
    step();
    idle();
    rst_n = 1'b1;
    rd_en = 1'b1; rd_addr = {4'd0, 4'd1, 4'd2};
    step();
    check("rst_r2_dropped", port(0), 32'h0);
    check("rst_r1_cleared", port(1), 32'h0);

    // Write then read R3 on two ports.
    idle(); we = 1'b1; wa = 4'd3; wd = 32'hDEAD_BEEF;
    step();
    idle(); rd_en = 1'b1; rd_addr = {4'd3, 4'd0, 4'd3};
    step();
    check("r3_p0", port(0), 32'hDEAD_BEEF);
    check("r3_p2", port(2), 32'hDEAD_BEEF);
    check("r0_p1", port(1), 32'h0);
    check("r3_valid", {31'b0, rd_valid}, 32'h1);

    // rd_en low: data holds, valid drops.
    idle(); rd_addr = {4'd0, 4'd0, 4'd0};
    step();
    check("hold_p0", port(0), 32'hDEAD_BEEF);
    check("hold_valid", {31'b0, rd_valid}, 32'h0);

    // Same-cycle write and read of R5.
    idle(); we = 1'b1; wa = 4'd5; wd = 32'h1234_5678;
    rd_en = 1'b1; rd_addr = {4'd0, 4'd5, 4'd0};
    step();
    check("bypass_p1", port(1), 32'h1234_5678);
    idle(); rd_en = 1'b1; rd_addr = {4'd3, 4'd5, 4'd5};
    step();
    check("r5_stored", port(0), 32'h1234_5678);
    check("r3_kept", port(2), 32'hDEAD_BEEF);

    // PC read offset and increment.
    idle(); we = 1'b1; wa = 4'd15; wd = 32'h100;
    step();
    check("pc_written", pc_out, 32'h100);
    idle(); rd_en = 1'b1; rd_addr = {4'd0, 4'd0, 4'd15};
    step();
    check("pc_read_ofs", port(0), 32'h108);
    idle(); pc_inc = 1'b1;
    step();
    check("pc_inc", pc_out, 32'h104);

    // PC write beats increment; read bypasses the written PC.
    idle(); we = 1'b1; wa = 4'd15; wd = 32'h2000; pc_inc = 1'b1;
    rd_en = 1'b1; rd_addr = {4'd0, 4'd0, 4'd15};
    step();
    check("pc_wr_prio", pc_out, 32'h2000);
    check("pc_wr_bypass", port(0), 32'h2008);

    // Increment does not bypass into a same-cycle read.
    idle(); pc_inc = 1'b1; rd_en = 1'b1; rd_addr = {4'd15, 4'd3, 4'd15};
    step();
    check("pc_pre_inc_p0", port(0), 32'h2008);
    check("pc_pre_inc_p2", port(2), 32'h2008);
    check("mixed_p1", port(1), 32'hDEAD_BEEF);
    check("pc_after_inc", pc_out, 32'h2004);

    // Wrap at the top of the address space.
    idle(); we = 1'b1; wa = 4'd15; wd = 32'hFFFF_FFFC;
    step();
    idle(); pc_inc = 1'b1; rd_en = 1'b1; rd_addr = {4'd0, 4'd0, 4'd15};
    step();
    check("wrap_read", port(0), 32'h0000_0004);
    check("wrap_pc", pc_out, 32'h0);

    // R14 is an ordinary register: no offset.
    idle(); we = 1'b1; wa = 4'd14; wd = 32'h0BAD_F00D;
    step();
    idle(); rd_en = 1'b1; rd_addr = {4'd5, 4'd14, 4'd15};
    step();
    check("r14_no_ofs", port(1), 32'h0BAD_F00D);
    check("r5_p2", port(2), 32'h1234_5678);
    check("pc0_read", port(0), 32'h8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
